// File: rtl/can_mac_tx_sequencer.sv
// can_mac_tx_sequencer
//   Turns a latched CAN 2.0A frame descriptor into a serial stream of
//   unstuffed frame bits for a downstream bit stuffer. The stream covers
//   SOF through the intermission. The stuffer pulls the stream with a
//   valid/ready handshake. CRC-15 is computed over SOF..DATA on the fly.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   tx_req              host request; the descriptor is latched from
//                       tx_id/tx_rtr/tx_dlc/tx_data
//   tx_abort            cancel the frame in progress (ignored when idle)
//   tx_ack              pulse: descriptor accepted
//   tx_done             pulse: last intermission bit handed over
//   tx_aborted          pulse: abort taken
//   busy                frame in progress
//   bit_out / valid     current frame bit / bit is valid
//   ready               stuffer accepts bit_out this cycle
//   stuffing_enable     high while SOF..CRC bits are presented
//
// bit_out, valid, busy and stuffing_enable are registered state outputs.
// The three pulses are decoded from the current state and inputs, so each
// pulse lines up with the cycle whose clock edge makes the decision.
module can_mac_tx_sequencer #(
  parameter int IFS_BITS = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tx_req,
  input  logic [10:0] tx_id,
  input  logic        tx_rtr,
  input  logic [3:0]  tx_dlc,
  input  logic [63:0] tx_data,
  input  logic        tx_abort,
  output logic        tx_ack,
  output logic        busy,
  output logic        tx_done,
  output logic        tx_aborted,
  output logic        bit_out,
  output logic        valid,
  input  logic        ready,
  output logic        stuffing_enable
);

  typedef enum logic [3:0] {
    S_IDLE, S_SOF, S_ID, S_RTR, S_IDE, S_R0, S_DLC, S_DATA,
    S_CRC, S_CRC_DEL, S_ACK, S_ACK_DEL, S_EOF, S_IFS
  } state_e;

  state_e      state_q;
  logic [5:0]  cnt_q;        // shared field counter, counts down to 0
  logic [14:0] crc_q;
  logic [10:0] id_q;
  logic        rtr_q;
  logic [3:0]  dlc_q;
  logic [63:0] data_q;       // shifted left as DATA bits go out
  logic        valid_q;
  logic        busy_q;
  logic        stuff_q;
  logic        bit_q;

  logic        xfer;
  logic [5:0]  cnt_m1;
  logic [14:0] crc_d;
  logic [3:0]  nbytes;
  logic [5:0]  data_last;

  assign xfer   = valid_q && ready;
  assign cnt_m1 = cnt_q - 6'd1;

  // CRC including the bit currently on bit_out (bit_q is the presented bit).
  always_comb begin
    crc_d = {crc_q[13:0], 1'b0} ^ ((bit_q ^ crc_q[14]) ? 15'h4599 : 15'h0000);
  end

  // Remote frames carry no data; DLC 9..15 still means 8 bytes.
  assign nbytes    = rtr_q ? 4'd0 : ((dlc_q > 4'd8) ? 4'd8 : dlc_q);
  assign data_last = 6'({nbytes, 3'b000} - 7'd1);

  assign tx_ack     = !reset && (state_q == S_IDLE) && tx_req;
  assign tx_aborted = !reset && (state_q != S_IDLE) && tx_abort;
  assign tx_done    = !reset && !tx_abort && (state_q == S_IFS) &&
                      (cnt_q == 6'd0) && ready;

  assign busy            = busy_q;
  assign valid           = valid_q;
  assign bit_out         = bit_q;
  assign stuffing_enable = stuff_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      crc_q   <= '0;
      id_q    <= '0;
      rtr_q   <= 1'b0;
      dlc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      stuff_q <= 1'b0;
      bit_q   <= 1'b0;
    end else if (state_q != S_IDLE && tx_abort) begin
      // Abort wins over any bit transfer in the same cycle.
      state_q <= S_IDLE;
      cnt_q   <= '0;
      crc_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      stuff_q <= 1'b0;
      bit_q   <= 1'b0;
    end else if (state_q == S_IDLE) begin
      if (tx_req) begin
        id_q    <= tx_id;
        rtr_q   <= tx_rtr;
        dlc_q   <= tx_dlc;
        data_q  <= tx_data;
        crc_q   <= '0;
        cnt_q   <= '0;
        state_q <= S_SOF;
        valid_q <= 1'b1;
        busy_q  <= 1'b1;
        stuff_q <= 1'b1;
        bit_q   <= 1'b0;           // SOF is dominant
      end
    end else if (xfer) begin
      // The enum order places SOF..DATA directly after IDLE.
      if (state_q <= S_DATA) crc_q <= crc_d;
      unique case (state_q)
        S_SOF: begin
          state_q <= S_ID;
          cnt_q   <= 6'd10;
          bit_q   <= id_q[10];
        end
        S_ID: begin
          if (cnt_q == 6'd0) begin
            state_q <= S_RTR;
            bit_q   <= rtr_q;
          end else begin
            cnt_q <= cnt_m1;
            bit_q <= id_q[cnt_m1[3:0]];
          end
        end
        S_RTR: begin
          state_q <= S_IDE;
          cnt_q   <= '0;
          bit_q   <= 1'b0;
        end
        S_IDE: begin
          state_q <= S_R0;
          cnt_q   <= '0;
          bit_q   <= 1'b0;
        end
        S_R0: begin
          state_q <= S_DLC;
          cnt_q   <= 6'd3;
          bit_q   <= dlc_q[3];
        end
        S_DLC: begin
          if (cnt_q != 6'd0) begin
            cnt_q <= cnt_m1;
            bit_q <= dlc_q[cnt_m1[1:0]];
          end else if (nbytes == 4'd0) begin
            state_q <= S_CRC;
            cnt_q   <= 6'd14;
            bit_q   <= crc_d[14];
          end else begin
            state_q <= S_DATA;
            cnt_q   <= data_last;
            bit_q   <= data_q[63];
          end
        end
        S_DATA: begin
          data_q <= {data_q[62:0], 1'b0};
          if (cnt_q == 6'd0) begin
            // First CRC bit must include the data bit leaving now.
            state_q <= S_CRC;
            cnt_q   <= 6'd14;
            bit_q   <= crc_d[14];
          end else begin
            cnt_q <= cnt_m1;
            bit_q <= data_q[62];
          end
        end
        S_CRC: begin
          if (cnt_q == 6'd0) begin
            state_q <= S_CRC_DEL;
            stuff_q <= 1'b0;
            bit_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_m1;
            bit_q <= crc_q[cnt_m1[3:0]];
          end
        end
        S_CRC_DEL: begin
          state_q <= S_ACK;
          bit_q   <= 1'b1;
        end
        S_ACK: begin
          state_q <= S_ACK_DEL;
          bit_q   <= 1'b1;
        end
        S_ACK_DEL: begin
          state_q <= S_EOF;
          cnt_q   <= 6'd6;
          bit_q   <= 1'b1;
        end
        S_EOF: begin
          bit_q <= 1'b1;
          if (cnt_q == 6'd0) begin
            state_q <= S_IFS;
            cnt_q   <= 6'(IFS_BITS - 1);
          end else begin
            cnt_q <= cnt_m1;
          end
        end
        S_IFS: begin
          if (cnt_q == 6'd0) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            bit_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_m1;
            bit_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          stuff_q <= 1'b0;
          bit_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_can_mac_tx_sequencer.sv
module tb_can_mac_tx_sequencer;
  localparam int IFS_BITS = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tx_req = 1'b0;
  logic [10:0] tx_id = '0;
  logic        tx_rtr = 1'b0;
  logic [3:0]  tx_dlc = '0;
  logic [63:0] tx_data = '0;
  logic        tx_abort = 1'b0;
  logic        tx_ack, busy, tx_done, tx_aborted, bit_out, valid, stuffing_enable;
  logic        ready = 1'b1;

  can_mac_tx_sequencer #(.IFS_BITS(IFS_BITS)) dut (
    .clk(clk), .reset(reset), .tx_req(tx_req), .tx_id(tx_id), .tx_rtr(tx_rtr),
    .tx_dlc(tx_dlc), .tx_data(tx_data), .tx_abort(tx_abort), .tx_ack(tx_ack),
    .busy(busy), .tx_done(tx_done), .tx_aborted(tx_aborted), .bit_out(bit_out),
    .valid(valid), .ready(ready), .stuffing_enable(stuffing_enable)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   ack_cnt = 0;
  int   abort_cnt = 0;
  int   ack_cyc[$];
  int   done_cyc[$];
  logic act_bit[$];
  logic act_se[$];
  logic exp_bit[$];
  logic saved_bit[$];
  int   exp_se_len = 0;
  logic rand_ready = 1'b0;

  // ready is either held high or randomised each cycle
  initial begin
    forever begin
      @(posedge clk);
      #1;
      ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor on the falling edge: records handed-over bits and pulse counts.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!reset && valid && ready) begin
      act_bit.push_back(bit_out);
      act_se.push_back(stuffing_enable);
    end
    if (tx_done) begin done_cnt = done_cnt + 1; done_cyc.push_back(cyc); end
    if (tx_ack) begin ack_cnt = ack_cnt + 1; ack_cyc.push_back(cyc); end
    if (tx_aborted) abort_cnt = abort_cnt + 1;
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame: field list, then CRC-15 over everything before it.
  task automatic build_exp(input logic [10:0] id, input logic rtr,
                           input logic [3:0] dlc, input logic [63:0] data);
    logic [14:0] crc;
    logic        fb;
    int          nb;
    exp_bit.delete();
    exp_bit.push_back(1'b0);
    for (int i = 10; i >= 0; i--) exp_bit.push_back(id[i]);
    exp_bit.push_back(rtr);
    exp_bit.push_back(1'b0);
    exp_bit.push_back(1'b0);
    for (int i = 3; i >= 0; i--) exp_bit.push_back(dlc[i]);
    nb = rtr ? 0 : ((int'(dlc) > 8) ? 8 : int'(dlc));
    for (int i = 0; i < nb * 8; i++) exp_bit.push_back(data[63 - i]);
    crc = '0;
    for (int k = 0; k < exp_bit.size(); k++) begin
      fb  = exp_bit[k] ^ crc[14];
      crc = {crc[13:0], 1'b0} ^ (fb ? 15'h4599 : 15'h0000);
    end
    for (int i = 14; i >= 0; i--) exp_bit.push_back(crc[i]);
    exp_se_len = exp_bit.size();
    repeat (10 + IFS_BITS) exp_bit.push_back(1'b1);
  endtask

  // Compare the captured stream against reps copies of the reference frame.
  task automatic check_stream(input string tag, input int reps);
    int n, mism, smism;
    n = exp_bit.size();
    check({tag, "_len"}, longint'(act_bit.size()), longint'(n * reps));
    mism = 0;
    smism = 0;
    for (int i = 0; i < act_bit.size() && i < n * reps; i++) begin
      if (act_bit[i] !== exp_bit[i % n]) mism++;
      if (act_se[i] !== ((i % n) < exp_se_len)) smism++;
    end
    check({tag, "_bits"}, longint'(mism), 0);
    check({tag, "_stuffen"}, longint'(smism), 0);
  endtask

  task automatic issue_req(input logic [10:0] id, input logic rtr,
                           input logic [3:0] dlc, input logic [63:0] data);
    @(posedge clk); #1;
    tx_id = id; tx_rtr = rtr; tx_dlc = dlc; tx_data = data;
    tx_req = 1'b1;
    @(posedge clk); #1;
    tx_req = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 4000 && done_cnt < target; i++) @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input string tag, input logic [10:0] id, input logic rtr,
                           input logic [3:0] dlc, input logic [63:0] data);
    int d0, a0, b0;
    build_exp(id, rtr, dlc, data);
    act_bit.delete();
    act_se.delete();
    d0 = done_cnt; a0 = ack_cnt; b0 = abort_cnt;
    issue_req(id, rtr, dlc, data);
    wait_done(d0 + 1);
    repeat (3) @(posedge clk);
    #1;
    check_stream(tag, 1);
    check({tag, "_done"}, longint'(done_cnt - d0), 1);
    check({tag, "_ack"}, longint'(ack_cnt - a0), 1);
    check({tag, "_aborted"}, longint'(abort_cnt - b0), 0);
    check({tag, "_idle_valid"}, longint'(valid), 0);
    check({tag, "_idle_busy"}, longint'(busy), 0);
  endtask

  initial begin
    int d0, a0, b0, mism;
    logic [63:0] rdata;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", longint'(valid), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_stuffen", longint'(stuffing_enable), 0);
    check("rst_bit", longint'(bit_out), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_valid", longint'(valid), 0);

    // Abort while idle does nothing
    tx_abort = 1'b1;
    @(posedge clk); #1;
    tx_abort = 1'b0;
    check("idle_abort_busy", longint'(busy), 0);
    check("idle_abort_pulse", longint'(abort_cnt), 0);

    // Frame A: id 0x123, one data byte 0xAA
    run_frame("frameA", 11'h123, 1'b0, 4'd1, 64'hAA00_0000_0000_0000);

    // Frame B: remote frame with dlc 8 -> no data, 47 bits total
    run_frame("frameB", 11'h5A5, 1'b1, 4'd8, 64'hFFFF_FFFF_FFFF_FFFF);
    check("frameB_total47", longint'(act_bit.size()), 47);

    // Frame C: dlc 15 -> 64 data bits; repeat with a random ready pattern
    rdata = {$urandom, $urandom};
    run_frame("frameC", 11'h7F0, 1'b0, 4'd15, rdata);
    check("frameC_total", longint'(act_bit.size()), 1 + 11 + 3 + 4 + 64 + 15 + 10 + IFS_BITS);
    saved_bit = act_bit;
    rand_ready = 1'b1;
    run_frame("frameC_rr", 11'h7F0, 1'b0, 4'd15, rdata);
    mism = 0;
    for (int i = 0; i < act_bit.size() && i < saved_bit.size(); i++)
      if (act_bit[i] !== saved_bit[i]) mism++;
    check("frameC_rr_vs_ready1", longint'(mism), 0);

    // Random descriptors under random ready
    for (int n = 0; n < 4; n++) begin
      run_frame($sformatf("rand%0d", n), 11'($urandom), 1'($urandom_range(0, 3) == 0),
                4'($urandom), {$urandom, $urandom});
    end
    rand_ready = 1'b0;

    // Abort during DATA
    rdata = {$urandom, $urandom};
    build_exp(11'h3C3, 1'b0, 4'd8, rdata);
    act_bit.delete(); act_se.delete();
    d0 = done_cnt; a0 = ack_cnt; b0 = abort_cnt;
    issue_req(11'h3C3, 1'b0, 4'd8, rdata);
    for (int i = 0; i < 200 && act_bit.size() < 25; i++) @(posedge clk);
    #1;
    tx_abort = 1'b1;
    @(posedge clk); #1;
    tx_abort = 1'b0;
    check("abort_valid", longint'(valid), 0);
    check("abort_stuffen", longint'(stuffing_enable), 0);
    check("abort_busy", longint'(busy), 0);
    repeat (20) @(posedge clk);
    #1;
    check("abort_pulse", longint'(abort_cnt - b0), 1);
    check("abort_no_done", longint'(done_cnt - d0), 0);
    check("abort_ack", longint'(ack_cnt - a0), 1);
    mism = 0;
    for (int i = 0; i < act_bit.size() && i < exp_bit.size(); i++)
      if (act_bit[i] !== exp_bit[i]) mism++;
    check("abort_prefix_bits", longint'(mism), 0);
    run_frame("after_abort", 11'h3C3, 1'b0, 4'd8, rdata);

    // Back-to-back with tx_req held high
    rdata = {$urandom, $urandom};
    build_exp(11'h2B6, 1'b0, 4'd3, rdata);
    act_bit.delete(); act_se.delete();
    ack_cyc.delete(); done_cyc.delete();
    d0 = done_cnt; a0 = ack_cnt;
    @(posedge clk); #1;
    tx_id = 11'h2B6; tx_rtr = 1'b0; tx_dlc = 4'd3; tx_data = rdata;
    tx_req = 1'b1;
    for (int i = 0; i < 4000 && ack_cnt < a0 + 2; i++) @(posedge clk);
    #1;
    tx_req = 1'b0;
    wait_done(d0 + 2);
    repeat (3) @(posedge clk);
    #1;
    check("b2b_ack_count", longint'(ack_cnt - a0), 2);
    check("b2b_done_count", longint'(done_cnt - d0), 2);
    if (ack_cyc.size() >= 2 && done_cyc.size() >= 1)
      check("b2b_ack_after_done", longint'(ack_cyc[1]), longint'(done_cyc[0] + 1));
    else
      check("b2b_ack_after_done", longint'(ack_cyc.size()), 2);
    check_stream("b2b", 2);

    // Reset pulsed during CRC, then a clean frame
    build_exp(11'h123, 1'b0, 4'd1, 64'hAA00_0000_0000_0000);
    act_bit.delete(); act_se.delete();
    d0 = done_cnt; b0 = abort_cnt;
    issue_req(11'h123, 1'b0, 4'd1, 64'hAA00_0000_0000_0000);
    for (int i = 0; i < 200 && act_bit.size() < 30; i++) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rstmid_valid", longint'(valid), 0);
    check("rstmid_busy", longint'(busy), 0);
    check("rstmid_stuffen", longint'(stuffing_enable), 0);
    check("rstmid_bit", longint'(bit_out), 0);
    check("rstmid_ack", longint'(tx_ack), 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rstmid_no_done", longint'(done_cnt - d0), 0);
    check("rstmid_no_abort", longint'(abort_cnt - b0), 0);
    run_frame("after_reset", 11'h123, 1'b0, 4'd1, 64'hAA00_0000_0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
